hazard_sb: RTL and testbench

Decode-stage hazard scoreboard for the 16-bit, 8-register pipelined core. It sits directly upstream of the register file. It tracks the destination registers of in-flight instructions in EX, MEM and WB, and stalls decode when a source operand is still pending. It also drives the register file write-port control (`write`, `writeregsel`) from its WB slot. The register file has no internal write-to-read bypass, so WB-stage writers are hazards too.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/hazard_sb_if.sv | 31 +++
 rtl/sb_slot.sv | 29 ++
 rtl/hazard_sb.sv | 51 +++++
 tb/tb_hazard_sb.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared widths, slot payload and helpers for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned REGSEL_W  = 3;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned NUM_SLOTS = 3;

  typedef logic [REGSEL_W-1:0] regsel_t;

  // One tracked pipeline stage: valid, writes-a-register, destination.
  typedef struct packed {
    logic    vld;
    logic    wen;
    regsel_t sel;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '{vld: 1'b0, wen: 1'b0, sel: '0};

  // A slot is a pending writer only when it is valid and writes.
  function automatic logic is_writer(input slot_t s);
    return s.vld & s.wen;
  endfunction

  // One-hot destination of a slot, or zero when it is not a writer.
  function automatic logic [NUM_REGS-1:0] writer_mask(input slot_t s);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (is_writer(s)) m[s.sel] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/hazard_sb_if.sv
// Decode <-> scoreboard handshake: ID operand/destination info in, stall/pending/RF-write out.
interface hazard_sb_if;
  import hazard_pkg::*;

  logic                id_valid;
  logic                id_rs_used;
  regsel_t             id_rs_sel;
  logic                id_rt_used;
  regsel_t             id_rt_sel;
  logic                id_wr_en;
  regsel_t             id_wr_sel;
  logic                flush;
  logic                stall;
  logic [NUM_REGS-1:0] pend;
  logic                rf_write;
  regsel_t             rf_writeregsel;
  logic                err;

  modport master (
    output id_valid, id_rs_used, id_rs_sel, id_rt_used, id_rt_sel,
           id_wr_en, id_wr_sel, flush,
    input  stall, pend, rf_write, rf_writeregsel, err
  );

  modport slave (
    input  id_valid, id_rs_used, id_rs_sel, id_rt_used, id_rt_sel,
           id_wr_en, id_wr_sel, flush,
    output stall, pend, rf_write, rf_writeregsel, err
  );

endinterface

// File: rtl/sb_slot.sv
// One tracked pipeline stage register with synchronous clear and bubble insertion.
module sb_slot
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  bubble_i,
  input  slot_t d_i,
  output slot_t q_o
);

  slot_t slot_q;
  slot_t slot_d;

  // A bubble replaces the incoming payload.
  always_comb begin
    slot_d = d_i;
    if (bubble_i) slot_d = SLOT_BUBBLE;
  end

  // Slot register; reset drops any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) slot_q <= SLOT_BUBBLE;
    else     slot_q <= slot_d;
  end

  assign q_o = slot_q;

endmodule

// File: rtl/hazard_sb.sv
// Decode-stage hazard scoreboard: tracks EX/MEM/WB writers, stalls ID on pending
// sources and drives the register-file write port from the WB slot.
module hazard_sb
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  hazard_sb_if.slave  sb
);

  slot_t               ex_d;
  slot_t               ex_q;
  slot_t               mem_q;
  slot_t               wb_q;
  logic                hazard;
  logic                stall;
  logic                accept;
  logic [NUM_REGS-1:0] pend;
  logic                err_d;
  logic                err_q;

  // Pending-writer map across all three tracked stages (WB included: no RF bypass).
  assign pend = writer_mask(ex_q) | writer_mask(mem_q) | writer_mask(wb_q);

  // Source operand hazards and the resulting ID stall / accept decision.
  always_comb begin
    hazard = (sb.id_rs_used & pend[sb.id_rs_sel]) | (sb.id_rt_used & pend[sb.id_rt_sel]);
    stall  = sb.id_valid & ~sb.flush & hazard;
    accept = sb.id_valid & ~stall & ~sb.flush;
    ex_d   = '{vld: 1'b1, wen: sb.id_wr_en, sel: sb.id_wr_sel};
    err_d  = ~sb.id_valid & (sb.id_wr_en | sb.id_rs_used | sb.id_rt_used);
  end

  // EX takes the accepted instruction, otherwise a bubble; MEM/WB always advance.
  sb_slot u_ex  (.clk(clk), .rst(rst), .bubble_i(~accept), .d_i(ex_d),  .q_o(ex_q));
  sb_slot u_mem (.clk(clk), .rst(rst), .bubble_i(1'b0),    .d_i(ex_q),  .q_o(mem_q));
  sb_slot u_wb  (.clk(clk), .rst(rst), .bubble_i(1'b0),    .d_i(mem_q), .q_o(wb_q));

  // One-cycle flag for ID fields asserted without a valid instruction.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign sb.stall          = stall;
  assign sb.pend           = pend;
  assign sb.rf_write       = is_writer(wb_q);
  assign sb.rf_writeregsel = is_writer(wb_q) ? wb_q.sel : regsel_t'(0);
  assign sb.err            = err_q;

endmodule

// File: tb/tb_hazard_sb.sv
// Scoreboard bench for hazard_sb: directed per-cycle vectors push expected outputs,
// an independent monitor pops and compares on the falling edge.
module tb_hazard_sb;

  typedef struct packed {
    logic       stall;
    logic [7:0] pend;
    logic       rfw;
    logic [2:0] rfs;
    logic       err;
  } exp_t;

  logic clk;
  logic rst;
  int   nvec;
  int   nmis;
  exp_t  exp_q[$];
  string tag_q[$];

  hazard_sb_if sb_if ();

  hazard_sb dut (.clk(clk), .rst(rst), .sb(sb_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string f, input logic [7:0] act, input logic [7:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, f, act, want);
    end
  endtask

  // Monitor: every falling edge with an expectation queued is one observed cycle.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, "stall", 8'(sb_if.stall),          8'(e.stall));
        chk(t, "pend",  sb_if.pend,               e.pend);
        chk(t, "rfw",   8'(sb_if.rf_write),       8'(e.rfw));
        chk(t, "rfsel", 8'(sb_if.rf_writeregsel), 8'(e.rfs));
        chk(t, "err",   8'(sb_if.err),            8'(e.err));
      end
    end
  end

  // Drive one cycle of ID inputs and queue the outputs expected during that cycle.
  task automatic cyc(input string tag, input logic r, input logic v,
                     input logic rsu, input logic [2:0] rs, input logic rtu, input logic [2:0] rt,
                     input logic we, input logic [2:0] ws, input logic fl,
                     input logic es, input logic [7:0] ep, input logic ew, input logic [2:0] eso,
                     input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    sb_if.id_valid   = v;
    sb_if.id_rs_used = rsu;
    sb_if.id_rs_sel  = rs;
    sb_if.id_rt_used = rtu;
    sb_if.id_rt_sel  = rt;
    sb_if.id_wr_en   = we;
    sb_if.id_wr_sel  = ws;
    sb_if.flush      = fl;
    e = '{stall: es, pend: ep, rfw: ew, rfs: eso, err: ee};
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input string tag, input logic [7:0] ep, input logic ew, input logic [2:0] eso,
                      input logic ee);
    cyc(tag, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, ep, ew, eso, ee);
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    rst = 1'b1;
    sb_if.id_valid = 1'b0; sb_if.id_rs_used = 1'b0; sb_if.id_rs_sel = 3'd0;
    sb_if.id_rt_used = 1'b0; sb_if.id_rt_sel = 3'd0; sb_if.id_wr_en = 1'b0;
    sb_if.id_wr_sel = 3'd0; sb_if.flush = 1'b0;

    //    tag       rst v  rsu rs    rtu rt    we ws    fl   stall pend  rfw rfs   err
    // Reset held two cycles with garbage on the inputs.
    cyc("rst0",    1, 1, 1, 3'd5, 1, 3'd2, 1, 3'd5, 0,   0, 8'h00, 0, 3'd0, 0);
    cyc("rst1",    1, 0, 1, 3'd5, 1, 3'd5, 1, 3'd5, 1,   0, 8'h00, 0, 3'd0, 0);
    idle("rst2", 8'h00, 0, 3'd0, 0);
    // RAW chain on r3: three stall cycles, WB write visible in the third.
    cyc("raw_p",   0, 1, 0, 3'd0, 0, 3'd0, 1, 3'd3, 0,   0, 8'h00, 0, 3'd0, 0);
    cyc("raw_s1",  0, 1, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0,   1, 8'h08, 0, 3'd0, 0);
    cyc("raw_s2",  0, 1, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0,   1, 8'h08, 0, 3'd0, 0);
    cyc("raw_s3",  0, 1, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0,   1, 8'h08, 1, 3'd3, 0);
    cyc("raw_acc", 0, 1, 1, 3'd3, 0, 3'd0, 0, 3'd0, 0,   0, 8'h00, 0, 3'd0, 0);
    idle("raw_i", 8'h00, 0, 3'd0, 0);
    // Independent writers r1,r2,r4,r5 reading r0/r7: no stalls.
    cyc("ind1",    0, 1, 1, 3'd0, 1, 3'd7, 1, 3'd1, 0,   0, 8'h00, 0, 3'd0, 0);
    cyc("ind2",    0, 1, 1, 3'd0, 1, 3'd7, 1, 3'd2, 0,   0, 8'h02, 0, 3'd0, 0);
    cyc("ind3",    0, 1, 1, 3'd0, 1, 3'd7, 1, 3'd4, 0,   0, 8'h06, 0, 3'd0, 0);
    cyc("ind4",    0, 1, 1, 3'd0, 1, 3'd7, 1, 3'd5, 0,   0, 8'h16, 1, 3'd1, 0);
    idle("ind_d1", 8'h34, 1, 3'd2, 0);
    idle("ind_d2", 8'h30, 1, 3'd4, 0);
    idle("ind_d3", 8'h20, 1, 3'd5, 0);
    idle("ind_d4", 8'h00, 0, 3'd0, 0);
    // Flush coinciding with a hazard on r6: no stall, ID instruction (writes r1) dropped.
    cyc("fl_p",    0, 1, 0, 3'd0, 0, 3'd0, 1, 3'd6, 0,   0, 8'h00, 0, 3'd0, 0);
    cyc("fl_hz",   0, 1, 1, 3'd6, 0, 3'd0, 1, 3'd1, 1,   0, 8'h40, 0, 3'd0, 0);
    idle("fl_d1", 8'h40, 0, 3'd0, 0);
    idle("fl_d2", 8'h40, 1, 3'd6, 0);
    idle("fl_d3", 8'h00, 0, 3'd0, 0);
    // Two in-flight writers of r2: pending until the younger leaves WB.
    cyc("dw_a",    0, 1, 0, 3'd0, 0, 3'd0, 1, 3'd2, 0,   0, 8'h00, 0, 3'd0, 0);
    cyc("dw_b",    0, 1, 0, 3'd0, 0, 3'd0, 1, 3'd2, 0,   0, 8'h04, 0, 3'd0, 0);
    cyc("dw_s1",   0, 1, 0, 3'd0, 1, 3'd2, 0, 3'd0, 0,   1, 8'h04, 0, 3'd0, 0);
    cyc("dw_s2",   0, 1, 0, 3'd0, 1, 3'd2, 0, 3'd0, 0,   1, 8'h04, 1, 3'd2, 0);
    cyc("dw_s3",   0, 1, 0, 3'd0, 1, 3'd2, 0, 3'd0, 0,   1, 8'h04, 1, 3'd2, 0);
    cyc("dw_acc",  0, 1, 0, 3'd0, 1, 3'd2, 0, 3'd0, 0,   0, 8'h00, 0, 3'd0, 0);
    // Protocol violation: fields without id_valid raise err for one cycle, nothing loads.
    cyc("pv",      0, 0, 1, 3'd7, 0, 3'd0, 1, 3'd7, 0,   0, 8'h00, 0, 3'd0, 0);
    idle("pv_e", 8'h00, 0, 3'd0, 1);
    idle("pv_c", 8'h00, 0, 3'd0, 0);
    // Reset mid-flight drops pending writes of r5 and r6.
    cyc("mr_a",    0, 1, 0, 3'd0, 0, 3'd0, 1, 3'd5, 0,   0, 8'h00, 0, 3'd0, 0);
    cyc("mr_b",    0, 1, 0, 3'd0, 0, 3'd0, 1, 3'd6, 0,   0, 8'h20, 0, 3'd0, 0);
    cyc("mr_rst",  1, 0, 0, 3'd0, 0, 3'd0, 0, 3'd0, 0,   0, 8'h60, 0, 3'd0, 0);
    idle("mr_d1", 8'h00, 0, 3'd0, 0);
    idle("mr_d2", 8'h00, 0, 3'd0, 0);
    // Same register as source and destination: not a hazard on its own.
    cyc("self",    0, 1, 1, 3'd3, 1, 3'd3, 1, 3'd3, 0,   0, 8'h00, 0, 3'd0, 0);
    idle("self_d", 8'h08, 0, 3'd0, 0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      nmis++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
